// File: rtl/psx_actuator_decoder.sv
// Rumble-motor command decoder: tracks one controller-port packet and pulls the
// small/large motor bytes out of a valid POLL packet using a byte-index map.
module psx_actuator_decoder #(
    parameter logic [4:0] MAX_IDX   = 5'd20,
    parameter logic [7:0] ADDR_BYTE = 8'h01,
    parameter logic [7:0] CMD_POLL  = 8'h42
) (
    input  logic       clk,
    input  logic       PPB_packet_reset,
    input  logic [7:0] PPB_command,
    input  logic       PPB_command_strobe,
    input  logic [4:0] map_small_idx,
    input  logic [4:0] map_large_idx,
    output logic       act_update,
    output logic       act_small,
    output logic [7:0] act_large,
    output logic       packet_is_poll
);

    typedef enum logic [2:0] {
        S_ADDR,
        S_CMD,
        S_PAD,
        S_PAYLOAD,
        S_DONE,
        S_IGNORE
    } state_t;

    state_t     r_state;
    logic [4:0] r_byte_idx;
    logic       r_act_update;
    logic       r_act_small;
    logic [7:0] r_act_large;
    logic       r_packet_is_poll;

    logic       w_small_en;
    logic       w_large_en;
    logic [4:0] w_last_idx;
    logic       w_small_hit;
    logic       w_large_hit;

    // Indices 0..2 are header/pad bytes, so payload can only start at 3.
    assign w_small_en = (map_small_idx >= 5'd3) && (map_small_idx <= MAX_IDX);
    assign w_large_en = (map_large_idx >= 5'd3) && (map_large_idx <= MAX_IDX);

    always_comb begin
        w_last_idx = 5'd0;
        if (w_small_en && w_large_en)
            w_last_idx = (map_small_idx > map_large_idx) ? map_small_idx : map_large_idx;
        else if (w_small_en)
            w_last_idx = map_small_idx;
        else if (w_large_en)
            w_last_idx = map_large_idx;
    end

    assign w_small_hit = w_small_en && (r_byte_idx == map_small_idx);
    assign w_large_hit = w_large_en && (r_byte_idx == map_large_idx);

    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            r_state          <= S_ADDR;
            r_byte_idx       <= 5'd0;
            r_act_update     <= 1'b0;
            r_act_small      <= 1'b0;
            r_act_large      <= 8'h00;
            r_packet_is_poll <= 1'b0;
        end else begin
            r_act_update <= 1'b0;
            if (PPB_command_strobe) begin
                if (r_byte_idx != 5'd31)
                    r_byte_idx <= r_byte_idx + 5'd1;
                case (r_state)
                    S_ADDR:
                        r_state <= (PPB_command == ADDR_BYTE) ? S_CMD : S_IGNORE;
                    S_CMD: begin
                        if (PPB_command == CMD_POLL) begin
                            r_state          <= S_PAD;
                            r_packet_is_poll <= 1'b1;
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                    S_PAD:
                        r_state <= (w_small_en || w_large_en) ? S_PAYLOAD : S_DONE;
                    S_PAYLOAD: begin
                        if (w_small_hit)
                            r_act_small <= PPB_command[0];
                        if (w_large_hit)
                            r_act_large <= PPB_command;
                        // Pulse lands in the cycle right after the last mapped byte.
                        if (r_byte_idx == w_last_idx) begin
                            r_state      <= S_DONE;
                            r_act_update <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign act_update     = r_act_update;
    assign act_small      = r_act_small;
    assign act_large      = r_act_large;
    assign packet_is_poll = r_packet_is_poll;

endmodule

// File: tb/tb_psx_actuator_decoder.sv
// Directed bench for psx_actuator_decoder: header validation, index mapping,
// disabled motors, short/aborted packets and the MAX_IDX boundary.
module tb_psx_actuator_decoder;

    logic       clk = 1'b0;
    logic       PPB_packet_reset = 1'b0;
    logic [7:0] PPB_command = 8'h00;
    logic       PPB_command_strobe = 1'b0;
    logic [4:0] map_small_idx = 5'h1F;
    logic [4:0] map_large_idx = 5'h1F;
    logic       act_update;
    logic       act_small;
    logic [7:0] act_large;
    logic       packet_is_poll;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    int upd_base;

    psx_actuator_decoder dut (
        .clk               (clk),
        .PPB_packet_reset  (PPB_packet_reset),
        .PPB_command       (PPB_command),
        .PPB_command_strobe(PPB_command_strobe),
        .map_small_idx     (map_small_idx),
        .map_large_idx     (map_large_idx),
        .act_update        (act_update),
        .act_small         (act_small),
        .act_large         (act_large),
        .packet_is_poll    (packet_is_poll)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (act_update === 1'b1) upd_cnt++;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        PPB_packet_reset = 1'b1;
        @(negedge clk);
        PPB_packet_reset = 1'b0;
    endtask

    // Returns at the falling edge after the capturing rising edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        PPB_command        = b;
        PPB_command_strobe = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0;
    endtask

    task automatic test_reset();
        PPB_packet_reset = 1'b1;
        idle(2);
        n_checks++; if (act_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b want 0", act_update); end
        n_checks++; if (act_small !== 1'b0) begin n_fail++; $display("FAIL reset_small: got %b want 0", act_small); end
        n_checks++; if (act_large !== 8'h00) begin n_fail++; $display("FAIL reset_large: got %h want 00", act_large); end
        n_checks++; if (packet_is_poll !== 1'b0) begin n_fail++; $display("FAIL reset_poll: got %b want 0", packet_is_poll); end
        PPB_packet_reset = 1'b0;
    endtask

    task automatic test_poll_basic();
        do_reset();
        map_small_idx = 5'd3; map_large_idx = 5'd4;
        upd_base = upd_cnt;
        send_byte(8'h01);
        n_checks++; if (packet_is_poll !== 1'b0) begin n_fail++; $display("FAIL basic_poll_b0: got %b want 0", packet_is_poll); end
        send_byte(8'h42);
        n_checks++; if (packet_is_poll !== 1'b1) begin n_fail++; $display("FAIL basic_poll_b1: got %b want 1", packet_is_poll); end
        send_byte(8'h00);
        send_byte(8'hFF);
        n_checks++; if (act_update !== 1'b0) begin n_fail++; $display("FAIL basic_early_upd: got %b want 0", act_update); end
        send_byte(8'h80);
        n_checks++; if (act_update !== 1'b1) begin n_fail++; $display("FAIL basic_upd: got %b want 1", act_update); end
        n_checks++; if (act_small !== 1'b1) begin n_fail++; $display("FAIL basic_small: got %b want 1", act_small); end
        n_checks++; if (act_large !== 8'h80) begin n_fail++; $display("FAIL basic_large: got %h want 80", act_large); end
        idle(1);
        n_checks++; if (act_update !== 1'b0) begin n_fail++; $display("FAIL basic_upd_width: got %b want 0", act_update); end
        send_byte(8'h55);
        send_byte(8'h00);
        idle(2);
        n_checks++; if (act_large !== 8'h80) begin n_fail++; $display("FAIL basic_hold_large: got %h want 80", act_large); end
        n_checks++; if (upd_cnt - upd_base !== 1) begin n_fail++; $display("FAIL basic_upd_count: got %0d want 1", upd_cnt - upd_base); end
        do_reset();
        n_checks++; if (act_large !== 8'h00) begin n_fail++; $display("FAIL basic_reset_large: got %h want 00", act_large); end
    endtask

    task automatic test_bad_cmd();
        do_reset();
        map_small_idx = 5'd3; map_large_idx = 5'd4;
        upd_base = upd_cnt;
        send_byte(8'h01); send_byte(8'h43); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h42); send_byte(8'hFF);
        idle(2);
        n_checks++; if (upd_cnt - upd_base !== 0) begin n_fail++; $display("FAIL badcmd_upd: got %0d want 0", upd_cnt - upd_base); end
        n_checks++; if (packet_is_poll !== 1'b0) begin n_fail++; $display("FAIL badcmd_poll: got %b want 0", packet_is_poll); end
        n_checks++; if (act_small !== 1'b0) begin n_fail++; $display("FAIL badcmd_small: got %b want 0", act_small); end
    endtask

    task automatic test_bad_addr();
        do_reset();
        map_small_idx = 5'd3; map_large_idx = 5'd4;
        upd_base = upd_cnt;
        send_byte(8'h02); send_byte(8'h42); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h80);
        idle(2);
        n_checks++; if (upd_cnt - upd_base !== 0) begin n_fail++; $display("FAIL badaddr_upd: got %0d want 0", upd_cnt - upd_base); end
        n_checks++; if (packet_is_poll !== 1'b0) begin n_fail++; $display("FAIL badaddr_poll: got %b want 0", packet_is_poll); end
        n_checks++; if (act_large !== 8'h00) begin n_fail++; $display("FAIL badaddr_large: got %h want 00", act_large); end
        n_checks++; if (act_small !== 1'b0) begin n_fail++; $display("FAIL badaddr_small: got %b want 0", act_small); end
    endtask

    task automatic test_small_disabled();
        do_reset();
        map_small_idx = 5'h1F; map_large_idx = 5'd5;
        upd_base = upd_cnt;
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        n_checks++; if (act_update !== 1'b0) begin n_fail++; $display("FAIL sdis_early_upd: got %b want 0", act_update); end
        send_byte(8'hC3);
        n_checks++; if (act_update !== 1'b1) begin n_fail++; $display("FAIL sdis_upd: got %b want 1", act_update); end
        n_checks++; if (act_large !== 8'hC3) begin n_fail++; $display("FAIL sdis_large: got %h want c3", act_large); end
        n_checks++; if (act_small !== 1'b0) begin n_fail++; $display("FAIL sdis_small: got %b want 0", act_small); end
    endtask

    task automatic test_equal_idx();
        do_reset();
        map_small_idx = 5'd4; map_large_idx = 5'd4;
        upd_base = upd_cnt;
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        n_checks++; if (act_update !== 1'b1) begin n_fail++; $display("FAIL eq_upd: got %b want 1", act_update); end
        n_checks++; if (act_small !== 1'b1) begin n_fail++; $display("FAIL eq_small: got %b want 1", act_small); end
        n_checks++; if (act_large !== 8'h01) begin n_fail++; $display("FAIL eq_large: got %h want 01", act_large); end
        send_byte(8'h01); send_byte(8'h01);
        idle(2);
        n_checks++; if (upd_cnt - upd_base !== 1) begin n_fail++; $display("FAIL eq_upd_count: got %0d want 1", upd_cnt - upd_base); end
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        map_small_idx = 5'd3; map_large_idx = 5'd6;
        upd_base = upd_cnt;
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h00); send_byte(8'h01); send_byte(8'hBB);
        // Byte 5 strobe and reset in the same cycle.
        @(negedge clk);
        PPB_command = 8'hCC; PPB_command_strobe = 1'b1; PPB_packet_reset = 1'b1;
        @(negedge clk);
        PPB_command_strobe = 1'b0; PPB_packet_reset = 1'b0;
        idle(2);
        n_checks++; if (upd_cnt - upd_base !== 0) begin n_fail++; $display("FAIL abort_upd: got %0d want 0", upd_cnt - upd_base); end
        n_checks++; if (act_small !== 1'b0) begin n_fail++; $display("FAIL abort_small: got %b want 0", act_small); end
        n_checks++; if (packet_is_poll !== 1'b0) begin n_fail++; $display("FAIL abort_poll: got %b want 0", packet_is_poll); end
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        n_checks++; if (act_update !== 1'b1) begin n_fail++; $display("FAIL abort_next_upd: got %b want 1", act_update); end
        n_checks++; if (act_small !== 1'b1) begin n_fail++; $display("FAIL abort_next_small: got %b want 1", act_small); end
        n_checks++; if (act_large !== 8'h04) begin n_fail++; $display("FAIL abort_next_large: got %h want 04", act_large); end
    endtask

    task automatic test_short_packet();
        do_reset();
        map_small_idx = 5'd3; map_large_idx = 5'd5;
        upd_base = upd_cnt;
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        idle(2);
        n_checks++; if (upd_cnt - upd_base !== 0) begin n_fail++; $display("FAIL short_upd: got %0d want 0", upd_cnt - upd_base); end
        do_reset();
        n_checks++; if (act_small !== 1'b0) begin n_fail++; $display("FAIL short_small: got %b want 0", act_small); end
    endtask

    task automatic test_both_disabled();
        do_reset();
        map_small_idx = 5'h1F; map_large_idx = 5'd2;
        upd_base = upd_cnt;
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'h7E);
        idle(2);
        n_checks++; if (upd_cnt - upd_base !== 0) begin n_fail++; $display("FAIL bdis_upd: got %0d want 0", upd_cnt - upd_base); end
        n_checks++; if (packet_is_poll !== 1'b1) begin n_fail++; $display("FAIL bdis_poll: got %b want 1", packet_is_poll); end
        n_checks++; if (act_large !== 8'h00) begin n_fail++; $display("FAIL bdis_large: got %h want 00", act_large); end
    endtask

    task automatic test_max_idx();
        do_reset();
        map_small_idx = 5'd21; map_large_idx = 5'd20;
        upd_base = upd_cnt;
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h00);
        for (int i = 3; i <= 20; i++) send_byte(8'(i + 16));
        n_checks++; if (act_update !== 1'b1) begin n_fail++; $display("FAIL max_upd: got %b want 1", act_update); end
        n_checks++; if (act_large !== 8'h24) begin n_fail++; $display("FAIL max_large: got %h want 24", act_large); end
        send_byte(8'h01); send_byte(8'h01);
        idle(2);
        n_checks++; if (act_small !== 1'b0) begin n_fail++; $display("FAIL max_small: got %b want 0", act_small); end
        n_checks++; if (upd_cnt - upd_base !== 1) begin n_fail++; $display("FAIL max_upd_count: got %0d want 1", upd_cnt - upd_base); end
    endtask

    initial begin
        test_reset();
        test_poll_basic();
        test_bad_cmd();
        test_bad_addr();
        test_small_disabled();
        test_equal_idx();
        test_reset_midpacket();
        test_short_packet();
        test_both_disabled();
        test_max_idx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
